// File: rtl/sdpb_stream_reader.sv
// sdpb_stream_reader: read-side controller for the 4096x8 simple dual-port
// line/frame store. Takes a (start address, length) command, issues one RAM
// read per cycle, hides the 1-cycle RAM read latency behind a 2-entry
// skid FIFO and emits the bytes as a valid/ready stream with a last flag.
module sdpb_stream_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              flush,
    output logic              ram_ceb,
    output logic              ram_oce,
    output logic [ADDR_W-1:0] ram_adb,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  remaining;

    // One read can be in the RAM pipeline at a time per cycle; its tag
    // travels alongside so the FIFO knows which byte closes the command.
    logic              inflight;
    logic              inflight_last;

    logic [1:0]        fifo_cnt;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [DATA_W-1:0] fifo_data [2];
    logic              fifo_last [2];

    logic              accept;
    logic              issue;
    logic              last_issue;
    logic              pop;
    logic              push;
    logic              flush_act;
    logic              drain_empty;
    logic [2:0]        occ;

    assign accept    = cmd_valid & cmd_ready;
    assign pop       = m_valid & m_ready;
    assign push      = inflight;
    assign flush_act = flush & (state != S_IDLE);

    // Slots already committed: bytes waiting in the FIFO plus the read in
    // flight. A new read is allowed only if it still fits after this
    // cycle's pop, which is what keeps the 2-entry FIFO from overflowing.
    assign occ        = {1'b0, fifo_cnt} + {2'b00, inflight};
    assign issue      = (state == S_RUN) && (remaining != '0) &&
                        (occ < (3'd2 + {2'b00, pop}));
    assign last_issue = issue && (remaining == LEN_W'(1));

    // DRAIN may finish once nothing is in flight and the FIFO is empty or
    // its final entry is being accepted right now.
    assign drain_empty = !inflight &&
                         ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign ram_ceb   = issue;
    assign ram_oce   = 1'b1;
    assign ram_adb   = rd_addr;
    assign m_valid   = (fifo_cnt != 2'd0);
    assign m_data    = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_last    = m_valid & fifo_last[rd_ptr];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush abandons any active command without done.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (cmd_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (last_issue) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (drain_empty) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Read address and byte countdown: loaded on accept, stepped per issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr   <= '0;
            remaining <= '0;
        end else if (accept) begin
            rd_addr   <= cmd_addr;
            remaining <= cmd_len;
        end else if (issue) begin
            rd_addr   <= rd_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
        end
    end

    // In-flight flag and last tag mirror the RAM's 1-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else if (flush_act) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= last_issue;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_cnt <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else if (flush_act) begin
            fifo_cnt <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO storage captures the returning RAM byte and its last tag.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= ram_dout;
            fifo_last[wr_ptr] <= inflight_last;
        end
    end

endmodule
